inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_pkg.sv | 18 +
 rtl/inst_mem.sv | 39 +++
 rtl/inst_loader.sv | 154 +++++++++++++++
 tb/tb_inst_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_pkg.sv
// Shared definitions for the instruction loader.
//
// Holds the default geometry of the instruction store and the loader FSM
// state encoding.  Both inst_loader and inst_mem import this package.
package inst_pkg;

    localparam int INST_AW    = 4;   // instruction address width
    localparam int INST_DW    = 8;   // instruction word width
    localparam int INST_DEPTH = 16;  // number of instruction words

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/inst_mem.sv
// Instruction storage array.
//
// DEPTH x DW words with one synchronous write port and one asynchronous
// read port.  Contents are deliberately not reset; the loader hides them
// until a load has completed.
//
// Ports:
//   clk    in   rising-edge clock for the write port
//   we     in   write enable
//   waddr  in   write address (AW bits)
//   wdata  in   write data (DW bits)
//   raddr  in   read address (AW bits)
//   rdata  out  word stored at raddr (combinational)
module inst_mem
    import inst_pkg::*;
#(
    parameter int AW    = INST_AW,
    parameter int DW    = INST_DW,
    parameter int DEPTH = INST_DEPTH
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: streams DEPTH words into inst_mem over a valid/ready
// port, then exposes them on a combinational read port.
//
// Handshake: in_ready depends only on the FSM state (high exactly in LOAD)
// and never on in_valid.  A word transfers on a rising edge where
// in_valid && in_ready; the source must hold in_data/in_valid until then,
// so nothing is lost while in_ready is low.
//
// Optional feature: define INST_LOADER_CHECKSUM_EN to accumulate a
// modulo-2**DW sum of the transferred words on csum.  Without it csum is
// tied to zero and no adder exists.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset
//   load_start in   pulse; starts a load from IDLE or DONE
//   load_abort in   cancels a load in progress (wins over a same-cycle word)
//   in_valid   in   in_data holds a word
//   in_data    in   instruction word (DW bits)
//   in_ready   out  loader accepts a word this cycle
//   load_done  out  all DEPTH words are loaded
//   inst       in   read address (AW bits)
//   instrom    out  word at inst once loaded, else 0
//   csum       out  checksum of loaded words (0 when feature disabled)
//   state      out  current FSM state, for observation
module inst_loader
    import inst_pkg::*;
#(
    parameter int AW    = INST_AW,
    parameter int DW    = INST_DW,
    parameter int DEPTH = INST_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          load_abort,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          load_done,
    input  logic [AW-1:0] inst,
    output logic [DW-1:0] instrom,
    output logic [DW-1:0] csum,
    output state_t        state
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] wr_addr;
    logic          xfer;
    logic          enter_load;
    logic          last_word;
    logic [DW-1:0] rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-derived outputs.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        load_done  = 1'b0;
        enter_load = 1'b0;
        xfer       = 1'b0;
        last_word  = (wr_addr == LAST_ADDR);
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d    = LOAD;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                // Abort wins: the word offered in the same cycle is dropped.
                // load_start is ignored here, so a load never restarts itself.
                if (load_abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    xfer = 1'b1;
                    if (last_word) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                load_done = 1'b1;
                if (load_start) begin
                    state_d    = LOAD;
                    enter_load = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write address: cleared on entry to LOAD, wraps to 0 after the last word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_addr <= '0;
        end else if (enter_load) begin
            wr_addr <= '0;
        end else if (xfer) begin
            wr_addr <= last_word ? '0 : wr_addr + 1'b1;
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    logic [DW-1:0] csum_q;

    // Wraps naturally at DW bits; holds its value outside transfers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            csum_q <= '0;
        end else if (enter_load) begin
            csum_q <= '0;
        end else if (xfer) begin
            csum_q <= csum_q + in_data;
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

    inst_mem #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (xfer),
        .waddr (wr_addr),
        .wdata (in_data),
        .raddr (inst),
        .rdata (rdata)
    );

    // Memory is only visible after a completed load; reset and abort hide it.
    assign instrom = load_done ? rdata : '0;
    assign state   = state_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader.
module tb_inst_loader;
    import inst_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_start = 1'b0;
    logic          load_abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          load_done;
    logic [AW-1:0] inst = '0;
    logic [DW-1:0] instrom;
    logic [DW-1:0] csum;
    state_t        state;

    inst_loader #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_abort (load_abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .load_done  (load_done),
        .inst       (inst),
        .instrom    (instrom),
        .csum       (csum),
        .state      (state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: expected memory image, pushed as words are driven.
    logic [DW-1:0] exp_q[$];

    typedef struct {
        string         name;
        logic [DW-1:0] base;
        logic [DW-1:0] step;
        bit            toggle;    // idle cycle (in_valid=0, junk data) before each word
        int            pulse_at;  // word index with a stray load_start, -1 for none
        logic [DW-1:0] exp_csum;  // checksum with the feature enabled
    } row_t;

    row_t rows[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    // Drive: assumes the caller is at a negedge.
    task automatic feed_words(input logic [DW-1:0] base, input logic [DW-1:0] step,
                              input bit toggle, input int pulse_at);
        logic [DW-1:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            if (toggle) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom_range(0, 255));
                @(negedge clk);
            end
            d = base + DW'(i) * step;
            in_valid = 1'b1;
            in_data  = d;
            exp_q.push_back(d);
            if (i == pulse_at) load_start = 1'b1;
            if (i == DEPTH - 1) check("done_low_before_last", 32'(load_done), 32'd0);
            @(negedge clk);
            load_start = 1'b0;
        end
        in_valid = 1'b0;
        in_data  = DW'($urandom_range(0, 255));
        check("done_after_last", 32'(load_done), 32'd1);
        check("ready_low_in_done", 32'(in_ready), 32'd0);
    endtask

    // Compare: sweep all addresses, popping expected words.
    task automatic sweep(input string name);
        logic [DW-1:0] e;
        for (int a = 0; a < DEPTH; a++) begin
            inst = AW'(a);
            #1;
            if (exp_q.size() == 0) begin
                check({name, "_queue_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check(name, 32'(instrom), 32'(e));
            end
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("ready_in_load", 32'(in_ready), 32'd1);
        check("done_low_in_load", 32'(load_done), 32'd0);
    endtask

    task automatic run_row(input int r);
        logic [DW-1:0] ec;
        start_load();
        feed_words(rows[r].base, rows[r].step, rows[r].toggle, rows[r].pulse_at);
        sweep({"image_", rows[r].name});
`ifdef INST_LOADER_CHECKSUM_EN
        ec = rows[r].exp_csum;
`else
        ec = '0;
`endif
        check({"csum_", rows[r].name}, 32'(csum), 32'(ec));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state), 32'(IDLE));
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_csum"}, 32'(csum), 32'd0);
        for (int k = 0; k < DEPTH; k++) exp_q.push_back('0);
        sweep({tag, "_instrom"});
    endtask

    initial begin
        rows[0] = '{"seq10",   8'h10, 8'h01, 1'b0, -1, 8'h78};
        rows[1] = '{"toggle",  8'h10, 8'h01, 1'b1, -1, 8'h78};
        rows[2] = '{"allff",   8'hFF, 8'h00, 1'b0, -1, 8'hF0};
        rows[3] = '{"seq00",   8'h00, 8'h01, 1'b0, -1, 8'h78};
        rows[4] = '{"restart", 8'h10, 8'h01, 1'b0,  6, 8'h78};

        // Reset
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Scenarios 1, 2, 4: plain load, gapped load, reload from DONE
        for (int r = 0; r < 3; r++) run_row(r);

        // Scenario 3: abort together with the 5th word
        start_load();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h30 + DW'(i);
            @(negedge clk);
        end
        in_valid   = 1'b1;
        in_data    = 8'h55;
        load_abort = 1'b1;
        @(negedge clk);
        load_abort = 1'b0;
        in_valid   = 1'b0;
        check("abort_state", 32'(state), 32'(IDLE));
        check("abort_ready", 32'(in_ready), 32'd0);
        check("abort_done", 32'(load_done), 32'd0);
        for (int k = 0; k < DEPTH; k++) exp_q.push_back('0);
        sweep("abort_instrom");
        // Abort and data outside LOAD do nothing
        load_abort = 1'b1;
        in_valid   = 1'b1;
        @(negedge clk);
        load_abort = 1'b0;
        in_valid   = 1'b0;
        check("abort_idle_ignored", 32'(state), 32'(IDLE));

        // Scenario 5: reset after 8 words, then full reload
        start_load();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + DW'(i);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check_reset_outputs("midreset");
        rst = 1'b1;
        run_row(3);

        // Scenario 6: load_start inside LOAD is ignored
        run_row(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
